// File: rtl/cpu_debug_ocimem_if.sv
// Bus bundle between the debug sysclk stage / CPU data master and the
// on-chip debug memory. The slave modport is the memory block's view.
interface cpu_debug_ocimem_if #(
  parameter int AW = 8
);
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic          take_no_action_ocimem_a;
  logic [AW-1:0] avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready;
  logic          monitor_error;

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest,
    output MonDReg, MonAReg, monitor_ready, monitor_error
  );

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest,
    input  MonDReg, MonAReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/cpu_debug_ocimem.sv
// Debug RAM shared between the JTAG debugger (command strobes + jdo word)
// and the CPU (slave port with waitrequest). One op runs at a time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | pick pending JTAG op first, else a CPU request
// JRD1  | JTAG read: address RAM with MonAReg, capture on exit
// JRD2  | JTAG read result visible; return to IDLE
// JWR   | JTAG write: result visible, RAM commit + MonAReg++ on exit
// CRD1  | CPU read: address RAM, load avs_readdata on exit
// CRD2  | CPU read complete (waitrequest low)
// CWR   | CPU write complete (waitrequest low), commit on exit
module cpu_debug_ocimem #(
  parameter int          AW       = 8,
  parameter int          DEPTH    = 256,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input logic clk,
  input logic reset,
  cpu_debug_ocimem_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_JRD1, S_JRD2, S_JWR, S_CRD1, S_CRD2, S_CWR
  } state_t;

  // Extra bit so DEPTH == 2^AW is representable in the range compare.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [0:DEPTH-1];

  logic          r_pend_valid;
  logic          r_pend_wr;
  logic [31:0]   r_pdata;

  logic [31:0]   r_mon_dreg;
  logic [AW-1:0] r_mon_areg;
  logic          r_mon_ready;
  logic          r_mon_error;
  logic [31:0]   r_readdata;

  logic w_stb_a, w_stb_b, w_stb_na, w_any_stb, w_load_pend, w_overrun;
  logic w_launch, w_jwr_start, w_j_in_range, w_c_in_range;
  logic w_unused_jdo;

  // ocimem_a outranks ocimem_b, which outranks the streaming read.
  assign w_stb_a     = bus.take_action_ocimem_a;
  assign w_stb_b     = bus.take_action_ocimem_b & ~bus.take_action_ocimem_a;
  assign w_stb_na    = bus.take_no_action_ocimem_a & ~bus.take_action_ocimem_a
                       & ~bus.take_action_ocimem_b;
  assign w_any_stb   = w_stb_a | w_stb_b | w_stb_na;
  assign w_load_pend = w_stb_b | w_stb_na | (w_stb_a & bus.jdo[34]);
  assign w_overrun   = w_any_stb & r_pend_valid;

  assign w_launch     = (r_state == S_IDLE) & r_pend_valid;
  assign w_jwr_start  = w_launch & r_pend_wr;
  assign w_j_in_range = ({1'b0, r_mon_areg} < DEPTH_W);
  assign w_c_in_range = ({1'b0, bus.avs_address} < DEPTH_W);
  assign w_unused_jdo = ^{bus.jdo[37:35], bus.jdo[2:0]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: JTAG op has priority in IDLE; accepted CPU ops run to completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend_valid)      w_state_nxt = r_pend_wr ? S_JWR : S_JRD1;
        else if (bus.avs_read)  w_state_nxt = S_CRD1;
        else if (bus.avs_write) w_state_nxt = S_CWR;
      end
      S_JRD1:  w_state_nxt = S_JRD2;
      S_CRD1:  w_state_nxt = S_CRD2;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-entry pending JTAG op; any new strobe replaces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_wr    <= 1'b0;
      r_pdata      <= '0;
    end else if (w_any_stb) begin
      r_pend_valid <= w_load_pend;
      r_pend_wr    <= w_stb_b;
      if (w_stb_b) r_pdata <= bus.jdo[34:3];
    end else if (w_launch) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Debugger-visible registers; a new ocimem_a command overrides a same-cycle completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_dreg  <= '0;
      r_mon_areg  <= '0;
      r_mon_ready <= 1'b0;
      r_mon_error <= 1'b0;
    end else begin
      if (r_state == S_JRD1) begin
        r_mon_dreg  <= w_j_in_range ? r_mem[r_mon_areg] : ERR_WORD;
        r_mon_ready <= 1'b1;
        if (!w_j_in_range) r_mon_error <= 1'b1;
        r_mon_areg  <= r_mon_areg + AW'(1);
      end else if (w_jwr_start) begin
        r_mon_dreg  <= r_pdata;
        r_mon_ready <= 1'b1;
        if (!w_j_in_range) r_mon_error <= 1'b1;
      end else if (r_state == S_JWR) begin
        r_mon_areg  <= r_mon_areg + AW'(1);
      end
      if (w_stb_a) begin
        r_mon_areg  <= bus.jdo[17 +: AW];
        r_mon_ready <= 1'b0;
        r_mon_error <= 1'b0;
      end
      if (w_overrun) r_mon_error <= 1'b1;
    end
  end

  // CPU read data, loaded as the read leaves CRD1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_readdata <= '0;
    else if (r_state == S_CRD1) r_readdata <= w_c_in_range ? r_mem[bus.avs_address] : '0;
  end

  // RAM writes commit on leaving JWR/CWR, so a reset inside the op drops them.
  always_ff @(posedge clk) begin
    if (r_state == S_JWR && w_j_in_range) begin
      r_mem[r_mon_areg] <= r_mon_dreg;
    end else if (r_state == S_CWR && w_c_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.avs_byteenable[b]) r_mem[bus.avs_address][8*b +: 8] <= bus.avs_writedata[8*b +: 8];
      end
    end
  end

  assign bus.avs_waitrequest = (bus.avs_read | bus.avs_write)
                               & ~((r_state == S_CRD2) | (r_state == S_CWR));
  assign bus.avs_readdata    = r_readdata;
  assign bus.MonDReg         = r_mon_dreg;
  assign bus.MonAReg         = r_mon_areg;
  assign bus.monitor_ready   = r_mon_ready;
  assign bus.monitor_error   = r_mon_error;

endmodule
